// File: rtl/latex_uart_tx.sv
// latex_uart_tx: byte FIFO feeding a registered 8N1 UART transmitter.
// A NUL byte from the upstream character stream goes out on the wire as a CR/LF pair.
module latex_uart_tx #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            frame_cnt
);
    // state    | meaning
    // IDLE     | line high, pop next byte when the FIFO holds one
    // START    | start bit (low) for CLK_DIV cycles
    // DATA     | 8 data bits, LSB first, CLK_DIV cycles each
    // STOP     | stop bit (high) for CLK_DIV cycles
    // CRLF_GAP | separator between CR and LF halves of an expanded NUL

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned TW      = $clog2(CLK_DIV);
    localparam int unsigned GAP_LEN = 0;

    localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [7:0]    CHAR_CR  = 8'h0D;
    localparam logic [7:0]    CHAR_LF  = 8'h0A;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] STOP     = 3'd3;
    localparam logic [2:0] CRLF_GAP = 3'd4;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    logic [2:0]    state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          lf_pend_q;
    logic          tx_q;
    logic          line_active_q;
    logic [15:0]   frame_cnt_q;
    logic          bit_end;
    logic          gap_end;
    logic          line_bit;

    // Full is judged from the count alone, so a same-cycle pop never admits a push at full.
    assign in_ready   = (count_q < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count_q;
    assign frame_cnt  = frame_cnt_q;
    assign tx         = tx_q;

    // line_active_q keeps busy high while the registered line still shows the final stop bit.
    assign busy = (count_q != '0) || (state_q != IDLE) || line_active_q;

    assign bit_end = (timer_q == BIT_LAST);
    assign gap_end = (timer_q == GAP_LAST);

    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shreg_q[0];
            default: line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            lf_pend_q     <= 1'b0;
            tx_q          <= 1'b1;
            line_active_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            tx_q          <= line_bit;
            line_active_q <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    timer_q   <= '0;
                    bit_idx_q <= '0;
                    if (pop) begin
                        state_q   <= START;
                        lf_pend_q <= (head == 8'h00);
                        shreg_q   <= (head == 8'h00) ? CHAR_CR : head;
                    end
                end
                START: begin
                    timer_q <= bit_end ? '0 : timer_q + TW'(1);
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    timer_q <= bit_end ? '0 : timer_q + TW'(1);
                    if (bit_end) begin
                        shreg_q <= {1'b0, shreg_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    timer_q <= bit_end ? '0 : timer_q + TW'(1);
                    if (bit_end) begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        if (lf_pend_q) begin
                            lf_pend_q <= 1'b0;
                            shreg_q   <= CHAR_LF;
                            // A zero-length gap chains the LF start bit straight onto the CR stop bit.
                            state_q   <= (GAP_LEN == 0) ? START : CRLF_GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                CRLF_GAP: begin
                    timer_q <= gap_end ? '0 : timer_q + TW'(1);
                    if (gap_end) begin
                        state_q <= START;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latex_uart_tx.sv
// Self-checking bench for latex_uart_tx: per-cycle comparison against a queue-based
// line model, plus a serial decoder and literal expectations for the directed scenarios.
module tb_latex_uart_tx;
    localparam int D     = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] frame_cnt;

    latex_uart_tx #(.CLK_DIV(D), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: FIFO of bytes and a queue of future line levels {frame_last, level}.
    logic [7:0]  m_fifo [$];
    logic [1:0]  m_line [$];
    logic        m_tx = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_shown = 1'b0;
    logic [15:0] m_frames = 16'h0000;
    logic        m_free;
    logic        m_acc;
    logic [1:0]  m_e;
    logic [7:0]  m_b;

    function automatic void add_frame(input logic [7:0] b);
        for (int i = 0; i < D; i++) m_line.push_back(2'b00);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < D; i++) m_line.push_back({1'b0, b[k]});
        for (int i = 0; i < D; i++) m_line.push_back({(i == D - 1), 1'b1});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            m_line.delete();
            m_tx     = 1'b1;
            m_busy   = 1'b0;
            m_shown  = 1'b0;
            m_frames = 16'h0000;
        end else begin
            m_free = (m_line.size() == 0);
            m_acc  = in_valid && (m_fifo.size() < DEPTH);
            if (!m_free) begin
                m_e     = m_line.pop_front();
                m_tx    = m_e[0];
                m_shown = 1'b1;
                if (m_e[1]) m_frames++;
            end else begin
                m_tx    = 1'b1;
                m_shown = 1'b0;
            end
            if (m_free && m_fifo.size() > 0) begin
                m_b = m_fifo.pop_front();
                if (m_b == 8'h00) begin
                    add_frame(8'h0D);
                    add_frame(8'h0A);
                end else begin
                    add_frame(m_b);
                end
            end
            if (m_acc) m_fifo.push_back(in_data);
            m_busy = (m_fifo.size() > 0) || (m_line.size() > 0) || m_shown;
        end
    end

    always @(posedge clk) begin
        #3;
        cyc++;
        check("tx", 32'(tx), 32'(m_tx));
        check("busy", 32'(busy), 32'(m_busy));
        check("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
        check("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    end

    // Serial decoder: samples each bit in its middle cycle.
    logic       dec_act = 1'b0;
    int         dec_ph = 0;
    logic [7:0] dec_b = 8'h00;
    logic [7:0] rx_q [$];

    always @(posedge clk) begin
        #3;
        if (!rst_n) begin
            dec_act = 1'b0;
        end else if (!dec_act) begin
            if (tx == 1'b0) begin
                dec_act = 1'b1;
                dec_ph  = 0;
            end
        end else begin
            dec_ph++;
            if (dec_ph >= D && dec_ph < 9 * D && (dec_ph % D) == D / 2)
                dec_b[dec_ph / D - 1] = tx;
            if (dec_ph == 9 * D + D / 2) begin
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(dec_b);
                dec_act = 1'b0;
            end
        end
    end

    task automatic expect_rx(input string name, input logic [7:0] exp);
        if (rx_q.size() == 0) check(name, 32'hFFFF_FFFF, 32'(exp));
        else check(name, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((busy !== 1'b0 || m_line.size() != 0 || m_fifo.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: still busy after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    logic [9:0]  pat41 = 10'b1010000010;
    logic [15:0] fc0;
    int          span;
    logic        gap_hi;
    logic        gap_lo;

    initial begin
        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_frames", 32'(frame_cnt), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0x41: latency and exact waveform
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #3;
        check("lat_k1_tx", 32'(tx), 32'd1);
        check("lat_k1_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #3;
            check("frame_41", 32'(tx), 32'(pat41[i / 4]));
        end
        check("busy_last_stop", 32'(busy), 32'd1);
        @(posedge clk); #3;
        check("busy_drop", 32'(busy), 32'd0);
        check("frames_after_41", 32'(frame_cnt), 32'd1);
        expect_rx("rx_41", 8'h41);
        wait_idle(200);

        // Back-to-back 0x55, 0xAA
        fc0 = frame_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        in_data  = 8'hAA;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #3;
        span   = 0;
        gap_hi = 1'b0;
        gap_lo = 1'b1;
        while (busy == 1'b1 && span < 300) begin
            if (span == 40) gap_hi = tx;
            if (span == 41) gap_lo = tx;
            span++;
            @(posedge clk); #3;
        end
        check("b2b_span", 32'(span), 32'd81);
        check("b2b_gap_high", 32'(gap_hi), 32'd1);
        check("b2b_second_start", 32'(gap_lo), 32'd0);
        check("b2b_frames", 32'(frame_cnt - fc0), 32'd2);
        expect_rx("rx_55", 8'h55);
        expect_rx("rx_AA", 8'hAA);
        wait_idle(200);

        // Full FIFO with the line stalled mid-frame
        push_byte(8'h10);
        repeat (8) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 7) begin
                check("fill7_count", 32'(fifo_count), 32'd7);
                check("fill7_ready", 32'(in_ready), 32'd1);
            end
            if (j == 8) begin
                check("full_count", 32'(fifo_count), 32'd8);
                check("full_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(j);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("full_hold", 32'(fifo_count), 32'd8);
        wait_idle(2000);
        expect_rx("rx_full_lead", 8'h10);
        for (int j = 0; j < 8; j++) expect_rx("rx_full_order", 8'hB0 + 8'(j));
        check("rx_full_extra", 32'(rx_q.size()), 32'd0);

        // NUL expansion
        fc0 = frame_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h78;
        @(negedge clk);
        in_data  = 8'h00;
        @(negedge clk);
        in_data  = 8'h79;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle(1000);
        check("nul_frames", 32'(frame_cnt - fc0), 32'd4);
        expect_rx("rx_nul_0", 8'h78);
        expect_rx("rx_nul_cr", 8'h0D);
        expect_rx("rx_nul_lf", 8'h0A);
        expect_rx("rx_nul_3", 8'h79);
        check("rx_nul_extra", 32'(rx_q.size()), 32'd0);

        // Asynchronous reset during DATA bit 3 with three bytes queued
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h61 + 8'(j);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tx", 32'(tx), 32'd1);
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(in_ready), 32'd1);
        check("async_frames", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h31;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_accept", 32'(fifo_count), 32'd1);
        wait_idle(200);
        check("post_rst_frames", 32'(frame_cnt), 32'd1);
        expect_rx("rx_post_rst", 8'h31);
        check("rx_post_rst_extra", 32'(rx_q.size()), 32'd0);

        // frame_cnt wrap
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        check("wrap_pre", 32'(frame_cnt), 32'h0000_FFFF);
        push_byte(8'h5A);
        wait_idle(200);
        check("wrap_post", 32'(frame_cnt), 32'd0);
        expect_rx("rx_wrap", 8'h5A);

        // Randomized traffic, including NULs and bursts into a full FIFO
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle(4000);
        rx_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/latex_uart_tx.md
LATEX_UART_TX -- requirements
Module: latex_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clock cycles per UART bit period; legal values are 2 to 65535.
REQ-002 SHALL have parameter DEPTH, default 8, meaning byte FIFO depth; legal values are powers of 2, 2 to 64.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_data, input, 8, ASCII byte from the upstream lhs/rhs character stream.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data is offered.
REQ-007 SHALL have port in_ready, output, 1, meaning the FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx, output, 1, the registered 8N1 serial line; idle level is high.
REQ-009 SHALL have port busy, output, 1, asserted while the FIFO is non-empty or the FSM is not IDLE.
REQ-010 SHALL have port fifo_count, output, $clog2(DEPTH)+1, the current FIFO occupancy.
REQ-011 SHALL have port frame_cnt, output, 16, the number of completed frames.

Function
REQ-012 in_ready SHALL equal (fifo_count < DEPTH), derived from the count only; a pop in the same cycle does not unblock a push at full.
REQ-013 A push SHALL occur on a rising edge with in_valid && in_ready; in_data is stored in arrival order.
REQ-014 A pop SHALL occur only when the FSM is IDLE and fifo_count > 0; fifo_count changes by +1, -1, or 0 on a simultaneous push and pop.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP and CRLF_GAP.
  - IDLE: on a pop, go to START.
  - START: send tx=0 for CLK_DIV cycles.
  - DATA: send 8 bits, LSB first, each for CLK_DIV cycles.
  - STOP: send tx=1 for CLK_DIV cycles.
REQ-016 A popped byte of 0x00 SHALL NOT be sent; it SHALL produce a frame of 0x0D, then pass through CRLF_GAP for 0 cycles, then a frame of 0x0A, consuming one FIFO entry.
REQ-017 At the end of STOP, the FSM SHALL go to IDLE.
  - A pending byte is popped in that IDLE cycle and START begins on the next edge.
  - Back-to-back frames are therefore separated by exactly one extra idle-high cycle.
REQ-018 Latency: with the FIFO empty and the FSM IDLE, a byte pushed on edge k SHALL be popped on edge k+1 and SHALL drive tx low from edge k+2.
REQ-019 The bit timer SHALL count 0 to CLK_DIV-1; bit boundaries occur only at terminal count.
REQ-020 frame_cnt SHALL increment by 1 at the end of each STOP, including each half of a CR/LF pair, and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 When pushes arrive with the FIFO full (in_valid=1, in_ready=0), the data SHALL be ignored, with no overwrite and no error state.
REQ-022 Pointer wrap-around at DEPTH SHALL preserve byte order.

Reset
REQ-023 While rst_n=0, the following SHALL hold, asynchronously, including mid-frame:
  - tx=1, busy=0, fifo_count=0, frame_cnt=0.
  - FSM in IDLE, bit timer 0.
  - in_ready=1.
REQ-024 Bytes held in the FIFO at reset SHALL be discarded, and a partially sent frame SHALL NOT be completed.
REQ-025 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-026 Single frame, CLK_DIV=4: push 0x41 into an empty block -> tx reads 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles; tx falls at edge k+2; frame_cnt reads 1; busy drops after 40 tx cycles.
REQ-027 Back-to-back, CLK_DIV=4: push 0x55 then 0xAA on consecutive edges -> two frames separated by exactly one high idle cycle (81 cycles total); frame_cnt reads 2.
REQ-028 Full FIFO, DEPTH=8: hold in_valid=1 with 10 distinct bytes and tx stalled mid-frame -> in_ready falls when fifo_count reaches 8; the blocked bytes are not stored; transmit order matches push order across pointer wrap.
REQ-029 NUL expansion: push 0x78, 0x00, 0x79 -> the serial bytes decode to 0x78, 0x0D, 0x0A, 0x79; frame_cnt reads 4; no 0x00 frame appears.
REQ-030 Reset mid-operation: assert rst_n=0 during DATA bit 3 with 3 bytes queued -> tx=1 and fifo_count=0 immediately without a clock; after release, a push of 0x31 transmits correctly and frame_cnt reads 1.
REQ-031 Counter wrap: preload or force 65535 frames, then send one frame -> frame_cnt reads 0x0000.
